// File: rtl/seq_shifter.sv
// seq_shifter: iterative one-bit-per-clock shifter with start/busy/done handshake.
// Modes: 00 ROR, 01 LSL, 10 LSR, 11 ASR. The result is held in sout until the next accepted start.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] count, count_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [WIDTH-1:0] sout_nxt;
  logic [WIDTH-1:0] stepped;
  logic             accept;

  // One-bit step of the current result using the mode latched at accept time
  always_comb begin
    stepped = sout;
    case (mode_q)
      2'b00:   stepped = {sout[0], sout[WIDTH-1:1]};
      2'b01:   stepped = {sout[WIDTH-2:0], 1'b0};
      2'b10:   stepped = {1'b0, sout[WIDTH-1:1]};
      2'b11:   stepped = {sout[WIDTH-1], sout[WIDTH-1:1]};
      default: stepped = sout;
    endcase
  end

  // Next-state and datapath update; DONE can accept a new start directly for back-to-back use
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mode_nxt  = mode_q;
    sout_nxt  = sout;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) accept = 1'b1;
      end
      S_SHIFT: begin
        if (count == '0) begin
          state_nxt = S_DONE;
        end else begin
          sout_nxt  = stepped;
          count_nxt = count - 1'b1;
        end
      end
      S_DONE: begin
        if (start) accept = 1'b1;
        else       state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (accept) begin
      sout_nxt  = in;
      count_nxt = amount;
      mode_nxt  = mode;
      state_nxt = S_SHIFT;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers: result, remaining step count and latched mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sout   <= '0;
      count  <= '0;
      mode_q <= '0;
    end else begin
      sout   <= sout_nxt;
      count  <= count_nxt;
      mode_q <= mode_nxt;
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=16, AMT_W=4) plus an AMT_W=5 instance for wide rotates.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start5;
  logic [15:0] din;
  logic [1:0]  mode;
  logic [3:0]  amount;
  logic [4:0]  amount5;
  logic        busy, done, busy5, done5;
  logic [15:0] sout, sout5;

  int n_cmp = 0;
  int n_err = 0;

  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in(din), .mode(mode),
    .amount(amount), .busy(busy), .done(done), .sout(sout)
  );

  seq_shifter #(.WIDTH(16), .AMT_W(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .in(din), .mode(mode),
    .amount(amount5), .busy(busy5), .done(done5), .sout(sout5)
  );

  always #5 clk = ~clk;

  // Reference result computed arithmetically (not by iterating single steps)
  function automatic logic [15:0] ref_shift(input logic [1:0] m, input logic [15:0] d,
                                            input logic [3:0] a);
    logic signed [15:0] s;
    int unsigned r;
    s = d;
    r = a;
    case (m)
      2'b00:   return (r == 0) ? d : ((d >> r) | (d << (16 - r)));
      2'b01:   return d << r;
      2'b10:   return d >> r;
      default: return s >>> r;
    endcase
  endfunction

  // Issue one operation on the AMT_W=4 instance; returns at the negedge where done is seen.
  // edges counts posedges from the accepting edge up to the one producing done.
  task automatic run_op(input logic [1:0] m, input logic [15:0] d, input logic [3:0] a,
                        output logic [15:0] res, output int edges, output int busy_cyc,
                        output bit timeout);
    @(negedge clk);
    start = 1'b1; mode = m; din = d; amount = a;
    @(posedge clk);
    edges = 1;
    busy_cyc = 0;
    @(negedge clk);
    start = 1'b0; din = ~d; mode = ~m; amount = ~a;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    res = sout;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start5 = 1'b0;
    din = '0; mode = '0; amount = '0; amount5 = '0;
    #12;
    n_cmp++;
    if ({busy, done, sout} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_state busy=%b done=%b sout=%h expected 0/0/0000", busy, done, sout);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lsl_basic;
    logic [15:0] r; int e, b; bit to;
    run_op(2'b01, 16'h0001, 4'd4, r, e, b, to);
    n_cmp++;
    if (to || r !== 16'h0010) begin
      n_err++;
      $display("FAIL lsl_basic_result got=%h timeout=%0d expected=0010", r, to);
    end
    n_cmp++;
    if (b !== 5) begin
      n_err++;
      $display("FAIL lsl_basic_busy_cycles got=%0d expected=5", b);
    end
    n_cmp++;
    if (e !== 6) begin
      n_err++;
      $display("FAIL lsl_basic_latency got=%0d expected=6", e);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || sout !== 16'h0010) begin
      n_err++;
      $display("FAIL lsl_basic_single_pulse done=%b sout=%h expected done=0 sout=0010", done, sout);
    end
  endtask

  task automatic test_modes;
    logic [1:0]  tm [3] = '{2'b11, 2'b10, 2'b00};
    logic [15:0] td [3] = '{16'h8000, 16'h8000, 16'h0001};
    logic [3:0]  ta [3] = '{4'd3, 4'd15, 4'd1};
    logic [15:0] tx [3] = '{16'hF000, 16'h0001, 16'h8000};
    logic [15:0] r; int e, b; bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(tm[i], td[i], ta[i], r, e, b, to);
      n_cmp++;
      if (to || r !== tx[i] || e !== int'(ta[i]) + 2) begin
        n_err++;
        $display("FAIL modes[%0d] got=%h latency=%0d expected=%h latency=%0d", i, r, e, tx[i],
                 int'(ta[i]) + 2);
      end
    end
  endtask

  task automatic test_amount_zero;
    logic [15:0] r; int e, b; bit to;
    for (int m = 0; m < 4; m++) begin
      run_op(2'(m), 16'hA5C3, 4'd0, r, e, b, to);
      n_cmp++;
      if (to || r !== 16'hA5C3 || e !== 2 || b !== 1) begin
        n_err++;
        $display("FAIL amount_zero[%0d] got=%h latency=%0d busy=%0d expected=a5c3 latency=2 busy=1",
                 m, r, e, b);
      end
    end
  endtask

  task automatic test_ror_wide;
    int e;
    bit seen;
    @(negedge clk);
    start5 = 1'b1; din = 16'h1234; mode = 2'b00; amount5 = 5'd16;
    @(posedge clk);
    e = 1;
    @(negedge clk);
    start5 = 1'b0; din = 16'hFFFF;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done5) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    n_cmp++;
    if (!seen || sout5 !== 16'h1234 || e !== 18) begin
      n_err++;
      $display("FAIL ror_wide got=%h latency=%0d seen=%0d expected=1234 latency=18", sout5, e, seen);
    end
  endtask

  task automatic test_start_ignored;
    int e;
    bit seen;
    @(negedge clk);
    start = 1'b1; mode = 2'b10; din = 16'hF000; amount = 4'd4;
    @(posedge clk);
    e = 1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); e++;
    @(negedge clk);
    start = 1'b1; mode = 2'b01; din = 16'hFFFF; amount = 4'd1;
    @(posedge clk); e++;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    n_cmp++;
    if (!seen || sout !== 16'h0F00 || e !== 6) begin
      n_err++;
      $display("FAIL start_ignored got=%h latency=%0d expected=0f00 latency=6", sout, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r; int e, b; bit to, seen;
    run_op(2'b10, 16'h8000, 4'd2, r, e, b, to);
    n_cmp++;
    if (to || r !== 16'h2000) begin
      n_err++;
      $display("FAIL b2b_first got=%h expected=2000", r);
    end
    start = 1'b1; mode = 2'b01; din = 16'h0003; amount = 4'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; din = 16'h5555;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || sout !== 16'h0003) begin
      n_err++;
      $display("FAIL b2b_no_bubble busy=%b done=%b sout=%h expected 1/0/0003", busy, done, sout);
    end
    e = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    n_cmp++;
    if (!seen || sout !== 16'h000C || e !== 4) begin
      n_err++;
      $display("FAIL b2b_second got=%h latency=%0d expected=000c latency=4", sout, e);
    end
  endtask

  task automatic test_async_reset;
    logic [15:0] r; int e, b; bit to, saw_done;
    @(negedge clk);
    start = 1'b1; mode = 2'b01; din = 16'h0001; amount = 4'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, sout} !== 18'd0) begin
      n_err++;
      $display("FAIL async_reset_immediate busy=%b done=%b sout=%h expected 0/0/0000",
               busy, done, sout);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL async_reset_no_done saw_activity=1 expected=0");
    end
    run_op(2'b01, 16'h0003, 4'd1, r, e, b, to);
    n_cmp++;
    if (to || r !== 16'h0006 || e !== 3) begin
      n_err++;
      $display("FAIL async_reset_recover got=%h latency=%0d expected=0006 latency=3", r, e);
    end
  endtask

  task automatic test_random;
    logic [15:0] r, d, x; logic [1:0] m; logic [3:0] a; int e, b; bit to;
    for (int i = 0; i < 300; i++) begin
      d = 16'($urandom);
      m = 2'($urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      x = ref_shift(m, d, a);
      run_op(m, d, a, r, e, b, to);
      n_cmp++;
      if (to || r !== x || e !== int'(a) + 2) begin
        n_err++;
        $display("FAIL random[%0d] mode=%0d in=%h amt=%0d got=%h latency=%0d expected=%h latency=%0d",
                 i, m, d, a, r, e, x, int'(a) + 2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_lsl_basic;
    test_modes;
    test_amount_zero;
    test_ror_wide;
    test_start_ignored;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
